pe_conv_row_p: RTL and testbench

Parametrised row processing element for the convolution-layer systolic array. It is the successor to the fixed 3-tap/8-bit PE. It keeps a K-tap sliding window of unsigned feature-map samples and a latched K-tap signed weight vector, and multiplies them tap by tap. It adds the upstream partial sum through a 2-stage pipeline and passes the result downstream. New over the previous generation: registered weight daisy-chain, valid qualification with window-fill tracking, saturating accumulation with a sticky overflow flag, and a synchronous clear.

---
 rtl/pe_conv_row_p.sv | 132 +++++++++++++
 tb/tb_pe_conv_row_p.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pe_conv_row_p.sv
// pe_conv_row_p: K-tap row PE with weight daisy-chain, valid tracking and saturating 2-stage accumulate
module pe_conv_row_p #(
    parameter int K       = 3,
    parameter int IFMAP_W = 8,
    parameter int WGT_W   = 8,
    parameter int PSUM_W  = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 wgt_load,
    input  logic [K*WGT_W-1:0]   wgt_in,
    output logic [K*WGT_W-1:0]   wgt_out,
    input  logic                 ifmap_in_valid,
    input  logic [IFMAP_W-1:0]   ifmap_in,
    output logic [IFMAP_W-1:0]   ifmap_out,
    input  logic [PSUM_W-1:0]    psum_in,
    output logic                 psum_out_valid,
    output logic [PSUM_W-1:0]    psum_out,
    output logic                 sat_flag
);
    localparam int PROD_W = IFMAP_W + WGT_W + 1;
    localparam int SUM_W  = PSUM_W + IFMAP_W + WGT_W + $clog2(K) + 1;
    localparam int FW     = $clog2(K + 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t                     state;
    logic [FW-1:0]              fill;
    logic [IFMAP_W-1:0]         taps [K];
    logic [IFMAP_W-1:0]         nt [K];
    logic [K*WGT_W-1:0]         wgt;
    logic signed [PROD_W-1:0]   prod [K];
    logic                       full;
    logic                       s1_valid;
    logic signed [PSUM_W-1:0]   s1_psum;
    logic signed [PROD_W-1:0]   s1_prod [K];
    logic signed [SUM_W-1:0]    sum;
    logic [SUM_W-PSUM_W:0]      upper;
    logic                       clamp;
    logic [PSUM_W-1:0]          sat_val;

    assign ifmap_out = taps[0];
    assign full      = ifmap_in_valid && (state == RUN || fill == FW'(K - 1));

    // post-shift window and tap products against the weights held before any load this cycle
    always_comb begin
        nt[0] = ifmap_in;
        for (int i = 1; i < K; i++) nt[i] = taps[i-1];
        for (int i = 0; i < K; i++)
            prod[i] = PROD_W'($signed({1'b0, nt[i]})) * PROD_W'($signed(wgt[i*WGT_W +: WGT_W]));
    end

    // weight register and its one-cycle-delayed copy for the next PE; clr leaves weights alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wgt     <= '0;
            wgt_out <= '0;
        end else if (en) begin
            wgt_out <= wgt;
            if (wgt_load) wgt <= wgt_in;
        end
    end

    // sliding window with fill tracking: FILL until K samples are held, then RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++) taps[i] <= '0;
            fill  <= '0;
            state <= FILL;
        end else if (en) begin
            if (clr) begin
                for (int i = 0; i < K; i++) taps[i] <= '0;
                fill  <= '0;
                state <= FILL;
            end else if (ifmap_in_valid) begin
                for (int i = 0; i < K; i++) taps[i] <= nt[i];
                if (state == FILL) begin
                    fill <= fill + FW'(1);
                    if (fill == FW'(K - 1)) state <= RUN;
                end
            end
        end
    end

    // stage 1: capture upstream partial sum and per-tap products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_psum  <= '0;
            for (int i = 0; i < K; i++) s1_prod[i] <= '0;
        end else if (en) begin
            s1_valid <= !clr && full;
            if (!clr && ifmap_in_valid) begin
                s1_psum <= psum_in;
                for (int i = 0; i < K; i++) s1_prod[i] <= prod[i];
            end
        end
    end

    // wide sum that cannot wrap, then clamp to the signed PSUM_W range
    always_comb begin
        sum = SUM_W'(s1_psum);
        for (int i = 0; i < K; i++) sum = sum + SUM_W'(s1_prod[i]);
        upper   = sum[SUM_W-1:PSUM_W-1];
        clamp   = !(&upper || ~|upper);
        sat_val = !clamp ? sum[PSUM_W-1:0] :
                  sum[SUM_W-1] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
    end

    // stage 2: registered saturated result and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum_out_valid <= 1'b0;
            psum_out       <= '0;
            sat_flag       <= 1'b0;
        end else if (en) begin
            if (clr) begin
                psum_out_valid <= 1'b0;
                psum_out       <= '0;
                sat_flag       <= 1'b0;
            end else begin
                psum_out_valid <= s1_valid;
                if (s1_valid) begin
                    psum_out <= sat_val;
                    if (clamp) sat_flag <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pe_conv_row_p.sv
// tb_pe_conv_row_p: randomized bench for pe_conv_row_p against a window/queue reference model
module tb_pe_conv_row_p;
    localparam int K  = 3;
    localparam int IW = 8;
    localparam int WW = 8;
    localparam int PW = 20;

    logic clk = 0, rst_n = 0, en = 0, clr = 0, wgt_load = 0, ifmap_in_valid = 0;
    logic [K*WW-1:0] wgt_in = '0, wgt_out;
    logic [IW-1:0]   ifmap_in = '0, ifmap_out;
    logic [PW-1:0]   psum_in = '0, psum_out;
    logic            psum_out_valid, sat_flag;

    always #5 clk = ~clk;

    pe_conv_row_p #(.K(K), .IFMAP_W(IW), .WGT_W(WW), .PSUM_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .wgt_load(wgt_load),
        .wgt_in(wgt_in), .wgt_out(wgt_out), .ifmap_in_valid(ifmap_in_valid),
        .ifmap_in(ifmap_in), .ifmap_out(ifmap_out), .psum_in(psum_in),
        .psum_out_valid(psum_out_valid), .psum_out(psum_out), .sat_flag(sat_flag)
    );

    int checks = 0, errors = 0;

    // reference model: accepted-sample history (newest first) and results due on a later en-cycle
    logic [K*WW-1:0] m_w, m_wout;
    int              hist[$];
    longint          m_val[$];
    bit              m_sat[$];
    int              m_due[$];
    int              ecnt = 0;
    logic            m_valid, m_flag;
    logic [PW-1:0]   m_out;
    logic [IW-1:0]   m_tap0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [K*WW-1:0] wpack(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic m_reset();
        hist.delete(); m_val.delete(); m_sat.delete(); m_due.delete();
        m_w = '0; m_wout = '0; m_valid = 0; m_flag = 0; m_out = '0; m_tap0 = '0;
    endtask

    task automatic m_edge();
        longint s;
        longint maxv = (longint'(1) << (PW - 1)) - 1;
        longint minv = -(longint'(1) << (PW - 1));
        if (!rst_n || !en) return;
        ecnt++;
        m_wout = m_w;
        if (clr) begin
            hist.delete(); m_val.delete(); m_sat.delete(); m_due.delete();
            m_valid = 0; m_out = '0; m_flag = 0; m_tap0 = '0;
        end else begin
            if (m_due.size() > 0 && m_due[0] == ecnt) begin
                m_valid = 1;
                m_out = PW'(m_val[0]);
                m_flag = m_flag | m_sat[0];
                void'(m_due.pop_front()); void'(m_val.pop_front()); void'(m_sat.pop_front());
            end else m_valid = 0;
            if (ifmap_in_valid) begin
                hist.push_front(int'(ifmap_in));
                m_tap0 = ifmap_in;
                if (hist.size() > K) void'(hist.pop_back());
                if (hist.size() == K) begin
                    s = longint'($signed(psum_in));
                    for (int i = 0; i < K; i++)
                        s += longint'(hist[i]) * longint'($signed(m_w[i*WW +: WW]));
                    m_sat.push_back(s > maxv || s < minv);
                    m_val.push_back(s > maxv ? maxv : s < minv ? minv : s);
                    m_due.push_back(ecnt + 1);
                end
            end
        end
        if (wgt_load) m_w = wgt_in;
    endtask

    task automatic step(input logic e, input logic c, input logic wl, input logic [K*WW-1:0] wv,
                        input logic v, input logic [IW-1:0] x, input logic [PW-1:0] p);
        en = e; clr = c; wgt_load = wl; wgt_in = wv; ifmap_in_valid = v; ifmap_in = x; psum_in = p;
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    // every cycle out of reset, all outputs are compared against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", longint'(psum_out_valid), longint'(m_valid));
            chk("psum_out", longint'(psum_out), longint'(m_out));
            chk("sat_flag", longint'(sat_flag), longint'(m_flag));
            chk("wgt_out", longint'(wgt_out), longint'(m_wout));
            chk("ifmap_out", longint'(ifmap_out), longint'(m_tap0));
        end
    end

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        chk("rst_valid", longint'(psum_out_valid), 0);
        chk("rst_psum", longint'(psum_out), 0);
        chk("rst_wgt_out", longint'(wgt_out), 0);

        step(1, 0, 1, wpack(1, 2, 3), 0, 0, 0);
        chk("load_wout_old", longint'(wgt_out), 0);
        step(1, 0, 0, '0, 1, 10, 0);
        chk("load_wout_new", longint'(wgt_out), longint'(wpack(1, 2, 3)));
        step(1, 0, 0, '0, 1, 20, 0);
        chk("fill_nv1", longint'(psum_out_valid), 0);
        step(1, 0, 0, '0, 1, 30, 5);
        chk("fill_nv2", longint'(psum_out_valid), 0);
        step(1, 0, 0, '0, 0, 0, 0);
        chk("lat_valid", longint'(psum_out_valid), 1);
        chk("lat_105", longint'($signed(psum_out)), 105);
        step(1, 0, 0, '0, 1, 40, 0);
        step(1, 0, 0, '0, 0, 0, 0);
        chk("run_160", longint'($signed(psum_out)), 160);

        step(1, 0, 1, wpack(1, 1, 1), 1, 50, 0);
        chk("reload_wout_old", longint'(wgt_out), longint'(wpack(1, 2, 3)));
        step(1, 0, 0, '0, 0, 0, 0);
        chk("reload_old_220", longint'($signed(psum_out)), 220);
        chk("reload_wout_new", longint'(wgt_out), longint'(wpack(1, 1, 1)));
        step(1, 0, 0, '0, 1, 60, 0);
        step(1, 0, 0, '0, 0, 0, 0);
        chk("reload_new_150", longint'($signed(psum_out)), 150);

        step(1, 0, 1, wpack(-128, -128, -128), 0, 0, 0);
        step(1, 0, 0, '0, 1, 255, 0);
        step(1, 0, 0, '0, 1, 255, 0);
        step(1, 0, 0, '0, 1, 255, PW'(-500000));
        step(1, 0, 0, '0, 0, 0, 0);
        chk("sat_psum", longint'($signed(psum_out)), -524288);
        chk("sat_flag_set", longint'(sat_flag), 1);
        step(1, 0, 1, wpack(1, 1, 1), 0, 0, 0);
        step(1, 0, 0, '0, 1, 5, 100);
        step(1, 0, 0, '0, 0, 0, 0);
        chk("sat_pos_615", longint'($signed(psum_out)), 615);
        chk("sat_sticky", longint'(sat_flag), 1);

        step(1, 0, 0, '0, 1, 7, 0);
        repeat (4) step(0, 1, 1, '1, 1, 99, 99);
        chk("stall_tap", longint'(ifmap_out), 7);
        chk("stall_valid", longint'(psum_out_valid), 0);
        step(1, 0, 0, '0, 0, 0, 0);
        chk("stall_267", longint'($signed(psum_out)), 267);

        step(1, 1, 0, '0, 0, 0, 0);
        chk("clr_valid", longint'(psum_out_valid), 0);
        chk("clr_sat", longint'(sat_flag), 0);
        chk("clr_wout", longint'(wgt_out), longint'(wpack(1, 1, 1)));
        step(1, 0, 0, '0, 1, 1, 0);
        step(1, 0, 0, '0, 1, 2, 0);
        step(1, 0, 0, '0, 1, 3, 0);
        chk("clr_refill_nv", longint'(psum_out_valid), 0);
        step(1, 0, 0, '0, 0, 0, 0);
        chk("clr_refill_6", longint'($signed(psum_out)), 6);

        step(1, 0, 0, '0, 1, 9, 0);
        #3 rst_n = 0;
        #1;
        chk("arst_valid", longint'(psum_out_valid), 0);
        chk("arst_psum", longint'(psum_out), 0);
        chk("arst_sat", longint'(sat_flag), 0);
        chk("arst_wout", longint'(wgt_out), 0);
        chk("arst_ifmap", longint'(ifmap_out), 0);
        m_reset();
        @(negedge clk);
        rst_n = 1;
        step(1, 0, 0, '0, 1, 1, 0);
        step(1, 0, 0, '0, 1, 2, 0);
        step(1, 0, 0, '0, 0, 0, 0);
        chk("arst_fill_nv", longint'(psum_out_valid), 0);

        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0,
                 K*WW'($urandom), $urandom_range(0, 3) != 0, IW'($urandom), PW'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
